// File: rtl/anim_sequencer.sv
// Animation frame sequencer: steps frames on LCD refresh boundaries and renders the current frame.
// pixel_data has one-cycle latency from addr_x/addr_y; there is no backpressure, frame_sync paces everything.
module anim_sequencer #(
    parameter int          LCD_W    = 132,
    parameter int          LCD_H    = 162,
    parameter int          FRAMES   = 8,
    parameter int          TICKS    = 4,
    parameter int          BOX_STEP = 4,
    parameter logic [15:0] BG_COLOR = 16'h2935,
    parameter logic [15:0] FG_COLOR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [1:0]  anim_sel,
    input  logic        loop_en,
    input  logic        frame_sync,
    input  logic [7:0]  addr_x,
    input  logic [7:0]  addr_y,
    output logic [15:0] pixel_data,
    output logic [3:0]  frame_idx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ARM, PLAY, HOLD} state_t;

    localparam int             CW     = 16;
    localparam logic [CW-1:0] W_C    = CW'(LCD_W);
    localparam logic [CW-1:0] H_C    = CW'(LCD_H);
    localparam logic [CW-1:0] BH     = CW'(LCD_H / FRAMES);
    localparam logic [CW-1:0] CX     = CW'(LCD_W / 2);
    localparam logic [CW-1:0] CY     = CW'(LCD_H / 2);
    localparam logic [CW-1:0] STEP_C = CW'(BOX_STEP);

    state_t      state;
    logic        go_q;
    logic        go_rise;
    logic [1:0]  cur_anim;
    logic [1:0]  next_anim;
    logic [3:0]  tick;
    logic [15:0] pix_nxt;

    assign go_rise = go & ~go_q;

    // The requested animation waits in next_anim and only becomes visible on the
    // frame_sync that leaves ARM, so a refresh never mixes two animations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            go_q       <= 1'b1;
            cur_anim   <= 2'd0;
            next_anim  <= 2'd0;
            frame_idx  <= 4'd0;
            tick       <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pixel_data <= BG_COLOR;
        end else begin
            go_q       <= go;
            done       <= 1'b0;
            pixel_data <= pix_nxt;
            case (state)
                IDLE, HOLD: begin
                    if (go_rise) begin
                        next_anim <= anim_sel;
                        state     <= ARM;
                        busy      <= 1'b1;
                    end
                end
                ARM: begin
                    if (frame_sync) begin
                        state     <= PLAY;
                        cur_anim  <= next_anim;
                        frame_idx <= 4'd0;
                        tick      <= 4'd0;
                    end
                end
                PLAY: begin
                    if (go_rise) begin
                        next_anim <= anim_sel;
                        state     <= ARM;
                    end else if (frame_sync) begin
                        if (tick == 4'(TICKS - 1)) begin
                            tick <= 4'd0;
                            if (frame_idx == 4'(FRAMES - 1)) begin
                                if (loop_en) begin
                                    frame_idx <= 4'd0;
                                end else begin
                                    state <= HOLD;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                frame_idx <= frame_idx + 4'd1;
                            end
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [CW-1:0] x, y, f, bar_lo, bar_hi, box_s, dx, dy;
    logic          fg;

    always_comb begin
        x      = CW'(addr_x);
        y      = CW'(addr_y);
        f      = CW'(frame_idx);
        bar_lo = f * BH;
        bar_hi = bar_lo + BH;
        box_s  = (f + CW'(1)) * STEP_C;
        dx     = (x >= CX) ? (x - CX) : (CX - x);
        dy     = (y >= CY) ? (y - CY) : (CY - y);
        fg     = 1'b0;
        if ((state == PLAY || state == HOLD) && x < W_C && y < H_C) begin
            case (cur_anim)
                2'd1:    fg = (y >= bar_lo) && (y < bar_hi);
                2'd2:    fg = (dx <= box_s) && (dy <= box_s);
                2'd3:    fg = frame_idx[0];
                default: fg = 1'b0;
            endcase
        end
        pix_nxt = fg ? FG_COLOR : BG_COLOR;
    end
endmodule

// File: tb/tb_anim_sequencer.sv
// Randomized bench for anim_sequencer: a frame-counting reference model feeds a scoreboard queue.
module tb_anim_sequencer;
    localparam int          LCD_W    = 132;
    localparam int          LCD_H    = 162;
    localparam int          FRAMES   = 8;
    localparam int          TICKS    = 4;
    localparam int          BOX_STEP = 4;
    localparam logic [15:0] BG       = 16'h2935;
    localparam logic [15:0] FG       = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [1:0]  anim_sel = 2'd0;
    logic        loop_en = 1'b0;
    logic        frame_sync = 1'b0;
    logic [7:0]  addr_x = 8'd0;
    logic [7:0]  addr_y = 8'd0;
    logic [15:0] pixel_data;
    logic [3:0]  frame_idx;
    logic        busy;
    logic        done;

    anim_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .anim_sel(anim_sel), .loop_en(loop_en),
        .frame_sync(frame_sync), .addr_x(addr_x), .addr_y(addr_y),
        .pixel_data(pixel_data), .frame_idx(frame_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        int          frame;
        bit          busy;
        bit          done;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done_seen = 0;

    // Reference model: phase 0 idle, 1 arm, 2 play, 3 hold; the frame is derived from
    // the number of frame_syncs counted since playback began.
    int m_phase = 0;
    int m_anim = 0;
    int m_pend = 0;
    int m_syncs = 0;
    int m_frame = 0;
    bit m_goq = 1'b1;
    bit m_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input int y);
        bit fg;
        int bh, s;
        fg = 1'b0;
        if (m_phase < 2 || x >= LCD_W || y >= LCD_H) return BG;
        case (m_anim)
            1: begin
                bh = LCD_H / FRAMES;
                fg = (y >= m_frame * bh) && (y < (m_frame + 1) * bh);
            end
            2: begin
                s  = (m_frame + 1) * BOX_STEP;
                fg = (iabs(x - LCD_W / 2) <= s) && (iabs(y - LCD_H / 2) <= s);
            end
            3: fg = (m_frame % 2) == 1;
            default: fg = 1'b0;
        endcase
        return fg ? FG : BG;
    endfunction

    task automatic model_step(input bit r, input bit g, input bit fs, input int sel, input bit le);
        bit rise;
        if (r) begin
            m_phase = 0; m_anim = 0; m_pend = 0; m_syncs = 0; m_frame = 0;
            m_goq = 1'b1; m_done = 1'b0;
            return;
        end
        rise   = g && !m_goq;
        m_goq  = g;
        m_done = 1'b0;
        case (m_phase)
            1: if (fs) begin
                m_phase = 2; m_anim = m_pend; m_syncs = 0; m_frame = 0;
            end
            2: begin
                if (rise) begin
                    m_pend = sel; m_phase = 1;
                end else if (fs) begin
                    if ((m_syncs + 1) % (FRAMES * TICKS) == 0 && !le) begin
                        m_phase = 3; m_done = 1'b1;
                    end else begin
                        m_syncs++;
                        m_frame = (m_syncs / TICKS) % FRAMES;
                    end
                end
            end
            default: if (rise) begin
                m_pend = sel; m_phase = 1;
            end
        endcase
    endtask

    // One clock of stimulus; the expectation for the following edge goes into the queue.
    task automatic drive(input bit r, input bit g, input bit fs, input int sel, input bit le,
                         input int x, input int y);
        exp_t e;
        @(negedge clk);
        rst = r; go = g; frame_sync = fs; anim_sel = 2'(sel); loop_en = le;
        addr_x = 8'(x); addr_y = 8'(y);
        e.pix = r ? BG : exp_pix(x, y);
        model_step(r, g, fs, sel, le);
        e.frame = m_frame;
        e.busy  = (m_phase == 1 || m_phase == 2);
        e.done  = m_done;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pixel_data", int'(pixel_data), int'(e.pix));
            chk("frame_idx", int'(frame_idx), e.frame);
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            if (done) n_done_seen++;
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_addr_cycle(input bit g, input int sel, input bit le);
        drive(1'b0, g, 1'b0, sel, le, $urandom_range(0, 140), $urandom_range(0, 170));
    endtask

    // Frame syncs separated by short random gaps, with targeted probes at frames 2 and 3.
    task automatic run_syncs(input int n, input bit g, input int sel, input bit le);
        for (int k = 0; k < n; k++) begin
            if (m_phase == 2 && m_frame == 2 && m_syncs % TICKS == 0) begin
                for (int yy = 0; yy < 170; yy++)
                    drive(1'b0, g, 1'b0, sel, le, $urandom_range(0, 131), yy);
            end
            if (m_phase == 2 && m_frame == 3 && m_syncs % TICKS == 0) begin
                drive(1'b0, g, 1'b0, sel, le, 50, 65);
                drive(1'b0, g, 1'b0, sel, le, 82, 97);
                drive(1'b0, g, 1'b0, sel, le, 49, 81);
                drive(1'b0, g, 1'b0, sel, le, 66, 98);
            end
            repeat ($urandom_range(1, 4)) rand_addr_cycle(g, sel, le);
            drive(1'b0, g, 1'b1, sel, le, $urandom_range(0, 140), $urandom_range(0, 170));
        end
    endtask

    task automatic start_seq(input int sel, input bit le);
        drive(1'b0, 1'b0, 1'b0, sel, le, 0, 0);
        drive(1'b0, 1'b1, 1'b0, sel, le, 0, 0);
        drive(1'b0, 1'b0, 1'b0, sel, le, 0, 0);
    endtask

    initial begin
        int g_r;
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        settle();
        chk("reset_pixel", int'(pixel_data), int'(BG));
        chk("reset_frame", int'(frame_idx), 0);
        chk("reset_busy", int'(busy), 0);

        // Idle sweep across the panel and a margin beyond it
        for (int yy = 0; yy < 166; yy++)
            for (int xx = 0; xx < 136; xx++)
                drive(1'b0, 1'b0, xx[0], 1, 1'b0, xx, yy);

        // Bar sweep, no loop
        start_seq(1, 1'b0);
        n_done_seen = 0;
        run_syncs(33, 1'b0, 1, 1'b0);
        repeat (3) rand_addr_cycle(1'b0, 1, 1'b0);
        settle();
        chk("bar_done_count", n_done_seen, 1);
        chk("bar_hold_frame", int'(frame_idx), FRAMES - 1);
        chk("bar_hold_busy", int'(busy), 0);

        // Box grow, restarted from HOLD
        start_seq(2, 1'b0);
        run_syncs(1 + 3 * TICKS + 2, 1'b0, 2, 1'b0);

        // Blink with looping
        start_seq(3, 1'b1);
        n_done_seen = 0;
        run_syncs(40, 1'b0, 3, 1'b1);
        settle();
        chk("loop_done_count", n_done_seen, 0);
        chk("loop_busy", int'(busy), 1);

        // go_rise coinciding with frame_sync in PLAY
        start_seq(1, 1'b0);
        run_syncs(1 + 2 * TICKS + 1, 1'b0, 1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1, 1'b0, 10, 45);
        settle();
        chk("collide_frame", int'(frame_idx), 2);
        chk("collide_busy", int'(busy), 1);
        drive(1'b0, 1'b1, 1'b0, 1, 1'b0, 10, 45);
        drive(1'b0, 1'b1, 1'b1, 1, 1'b0, 10, 45);
        settle();
        chk("collide_restart_frame", int'(frame_idx), 0);
        run_syncs(6, 1'b1, 1, 1'b0);

        // Reset mid-PLAY with go held high, then no restart until go re-rises
        drive(1'b1, 1'b1, 1'b0, 2, 1'b0, 66, 81);
        run_syncs(5, 1'b1, 2, 1'b0);
        settle();
        chk("rst_idle_busy", int'(busy), 0);
        chk("rst_idle_frame", int'(frame_idx), 0);
        start_seq(2, 1'b0);
        run_syncs(2 * TICKS, 1'b0, 2, 1'b0);

        // Fully random phase
        g_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) g_r = 1 - g_r;
            drive($urandom_range(0, 399) == 0, g_r[0], $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 150), $urandom_range(0, 180));
        end

        settle();
        settle();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
